alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PSW_RST, default 16'h0000: psw value after reset.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid / req_ready  input / output  1 / 1  instruction handshake; accepted on an edge where both are 1.
REQ-005 req_instr  input  6  ALU opcode: bit0 = byte, bits[4:1] = operation.
REQ-006 req_src, req_dst  input  3 each  register indices.
REQ-007 req_imm  input  16  immediate operand; req_use_imm  input  1  selects req_imm as op2.
REQ-008 req_upd_psw  input  1  passed to ALU instr_opt.
REQ-009 rf_raddr_a, rf_raddr_b  output  3 each  register-file read addresses (src, dst); rf_rdata_a, rf_rdata_b  input  16 each  combinational read data.
REQ-010 rf_we  output  1;  rf_waddr  output  3;  rf_wdata  output  16  register-file write port.
REQ-011 alu_op1, alu_op2, alu_psw_i  output  16 each;  alu_instr  output  6;  alu_instr_opt  output  1;  alu_E  output  1  ALU strobe.
REQ-012 alu_result, alu_psw_o  input  16 each  ALU outputs.
REQ-013 psw  output  16  architectural PSW (V=4, N=2, Z=1, C=0).
REQ-014 psw_ld  input  1;  psw_ld_data  input  16  external PSW load.
REQ-015 done, err  output  1 each  single-cycle completion / illegal-opcode pulses;  busy  output  1.

Function
REQ-016 FSM states IDLE, READ, EXEC, CAPT, WB; req_ready = 1 only in IDLE; busy = not IDLE.
REQ-017 On acceptance (edge 0), latch instr, src, dst, imm, use_imm, upd_psw; go to READ.
REQ-018 READ (cycle 1): rf_raddr_a = src, rf_raddr_b = dst; at end of cycle, latch op1 = rf_rdata_b, op2 = use_imm ? imm : rf_rdata_a.
REQ-019 Legal opcode: instr[5] = 0 and instr[4:0] <= 5'd27; illegal in READ -> WB directly (cycle 2) with err = 1, no ALU strobe, no rf write, psw unchanged.
REQ-020 EXEC (cycle 2): alu_E = 1 for exactly one cycle, registered, glitch-free; alu_op1/op2/instr/instr_opt/psw_i stable from cycle 2 through cycle 3; alu_psw_i = psw.
REQ-021 CAPT (cycle 3): alu_E = 0; at end of cycle capture alu_result and alu_psw_o.
REQ-022 WB (cycle 4): done = 1; rf_we = 1, rf_waddr = dst, rf_wdata = captured result, except cmp/cmp.b (instr[4:1] = 4'b0101) and bit/bit.b (4'b1001), which assert no write.
REQ-023 WB: psw <= captured alu_psw_o at end of cycle (legal ops only).
REQ-024 Latency: done 4 cycles after acceptance (2 if illegal); req_ready high again the cycle after WB; back-to-back throughput one instruction per 5 cycles.
REQ-025 psw_ld honored only in IDLE (psw <= psw_ld_data at next edge); ignored while busy.
REQ-026 psw_ld and request acceptance on the same IDLE edge: both take effect; the instruction uses the loaded psw.
REQ-027 alu_E, rf_we, done, err are 0 in all states other than specified.
REQ-028 Datapath operands and results 16-bit, no extension or truncation by this block.

Reset
REQ-029 rst_n low: immediately state = IDLE, psw = PSW_RST, req_ready = 1, all other outputs and latched registers 0.
REQ-030 Reset mid-operation aborts the instruction; no rf_we or done for it after rst_n rises.

Verification
REQ-031 Reset, then release -> psw = 16'h0000, req_ready = 1, busy = 0, alu_E = 0, rf_we = 0.
REQ-032 add (6'b000000), R2 = 16'h0005, R3 = 16'h0003, src = 3, dst = 2, upd_psw = 1 -> alu_E high in cycle 2 only; cycle 4: rf_we = 1, waddr = 2, wdata = 16'h0008, done = 1; psw bits Z, N = 0.
REQ-033 cmp (6'b001010), R0 = 16'h1234, imm = 16'h1234, use_imm = 1, upd_psw = 1 -> no rf_we; psw[1] = 1 after cycle 4.
REQ-034 req_instr = 6'b111111 -> err = 1 and done = 1 in cycle 2; alu_E never high; rf_we = 0; psw unchanged.
REQ-035 rst_n pulsed low during EXEC -> rf_we and done never assert; req_ready = 1 after release; psw = 16'h0000.
REQ-036 psw_ld_data = 16'h0001 with addc (6'b000010), R1 = 1, imm = 1, accepted same edge -> wdata = 16'h0003; psw_ld while busy leaves psw unchanged.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction request handshake between an issuing agent and alu_sequencer.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_instr;
  logic [2:0]  req_src;
  logic [2:0]  req_dst;
  logic [15:0] req_imm;
  logic        req_use_imm;
  logic        req_upd_psw;

  modport master (
    output req_valid, req_instr, req_src, req_dst, req_imm, req_use_imm, req_upd_psw,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_instr, req_src, req_dst, req_imm, req_use_imm, req_upd_psw,
    output req_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, strobes an external ALU once,
// captures its result/flags and writes back to the register file and PSW.
module alu_sequencer #(
  parameter logic [15:0] PSW_RST = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    req,
  output logic [2:0]        rf_raddr_a,
  output logic [2:0]        rf_raddr_b,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic [15:0]       alu_op1,
  output logic [15:0]       alu_op2,
  output logic [15:0]       alu_psw_i,
  output logic [5:0]        alu_instr,
  output logic              alu_instr_opt,
  output logic              alu_E,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       alu_psw_o,
  output logic [15:0]       psw,
  input  logic              psw_ld,
  input  logic [15:0]       psw_ld_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, CAPT, WB} state_t;

  typedef struct packed {
    logic [5:0]  instr;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [15:0] imm;
    logic        use_imm;
    logic        upd_psw;
  } req_t;

  state_t      state, state_nxt;
  req_t        cur;
  logic [15:0] op1, op2, res_q, pswo_q;
  logic        alu_e_q;
  logic        accept, legal, no_wr;

  assign accept = req.req_valid && (state == IDLE);
  assign legal  = !cur.instr[5] && (cur.instr[4:0] <= 5'd27);
  // cmp and bit only produce flags
  assign no_wr  = (cur.instr[4:1] == 4'b0101) || (cur.instr[4:1] == 4'b1001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req.req_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    rf_we         = 1'b0;
    case (state)
      IDLE: begin
        req.req_ready = 1'b1;
        busy          = 1'b0;
        if (req.req_valid) state_nxt = READ;
      end
      READ: state_nxt = legal ? EXEC : WB;
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        err       = !legal;
        rf_we     = legal && !no_wr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      op1     <= '0;
      op2     <= '0;
      res_q   <= '0;
      pswo_q  <= '0;
      alu_e_q <= 1'b0;
      psw     <= PSW_RST;
    end else begin
      // strobe comes straight from a flop so the ALU never sees a glitch
      alu_e_q <= (state == READ) && legal;
      if (accept)
        cur <= '{instr: req.req_instr, src: req.req_src, dst: req.req_dst,
                 imm: req.req_imm, use_imm: req.req_use_imm, upd_psw: req.req_upd_psw};
      if (state == READ) begin
        op1 <= rf_rdata_b;
        op2 <= cur.use_imm ? cur.imm : rf_rdata_a;
      end
      if (state == CAPT) begin
        res_q  <= alu_result;
        pswo_q <= alu_psw_o;
      end
      if (state == IDLE && psw_ld)  psw <= psw_ld_data;
      else if (state == WB && legal) psw <= pswo_q;
    end
  end

  assign rf_raddr_a    = cur.src;
  assign rf_raddr_b    = cur.dst;
  assign rf_waddr      = cur.dst;
  assign rf_wdata      = res_q;
  assign alu_op1       = op1;
  assign alu_op2       = op2;
  assign alu_psw_i     = psw;
  assign alu_instr     = cur.instr;
  assign alu_instr_opt = cur.upd_psw;
  assign alu_E         = alu_e_q;

endmodule
